// File: rtl/fp32_operand_loader_if.sv
// Byte-side and core-side handshake bundle for fp32_operand_loader.
// master = upstream byte source / downstream core environment, slave = the loader itself.
interface fp32_operand_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        op_sel_in;
    logic        clear;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_sel;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  byte_idx;
    logic        timeout_flag;

    modport master (
        output byte_in, byte_valid, op_sel_in, clear, op_ready,
        input  byte_ready, op_a, op_b, op_sel, op_valid, byte_idx, timeout_flag
    );

    modport slave (
        input  byte_in, byte_valid, op_sel_in, clear, op_ready,
        output byte_ready, op_a, op_b, op_sel, op_valid, byte_idx, timeout_flag
    );
endinterface

// File: rtl/fp32_operand_loader.sv
// Assembles two big-endian FP32 operands from an 8-bit byte stream and issues them to the core.
// Optional partial-load idle timeout is enabled by defining LOADER_TIMEOUT_EN.
module fp32_operand_loader #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input logic                  clk,
    input logic                  rst,
    fp32_operand_loader_if.slave bus
);

    typedef enum logic {
        LOAD  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [2:0]  idx;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic        sel_q;
    logic        to_flag;
    logic        accept;
    logic        timeout_hit;
    logic [1:0]  lane;

    if ((2 ** TO_W) <= TIMEOUT_CYCLES) begin : g_param_check
        $error("TO_W too narrow for TIMEOUT_CYCLES");
    end

    // clear beats a same-cycle byte, so it also gates acceptance
    assign accept = bus.byte_valid && (state == LOAD) && !bus.clear;
    assign lane   = 2'd3 - idx[1:0];

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nx       = state;
        bus.byte_ready = 1'b0;
        bus.op_valid   = 1'b0;
        case (state)
            LOAD: begin
                bus.byte_ready = 1'b1;
                if (accept && (idx == 3'd7)) state_nx = ISSUE;
            end
            ISSUE: begin
                bus.op_valid = 1'b1;
                if (bus.op_ready) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
        if (bus.clear) state_nx = LOAD;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx   <= 3'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            sel_q <= 1'b0;
        end else if (bus.clear) begin
            idx <= 3'd0;
        end else if (accept) begin
            idx <= idx + 3'd1;
            if (idx[2]) b_q[{lane, 3'b000} +: 8] <= bus.byte_in;
            else        a_q[{lane, 3'b000} +: 8] <= bus.byte_in;
            if (idx == 3'd0) sel_q <= bus.op_sel_in;
        end else if (timeout_hit) begin
            // stale operand bytes stay in place and are simply overwritten by the next load
            idx <= 3'd0;
        end
    end

`ifdef LOADER_TIMEOUT_EN
    logic [TO_W-1:0] idle_cnt;

    assign timeout_hit = (state == LOAD) && (idx != 3'd0) && !accept && !bus.clear
                         && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (bus.clear || accept || timeout_hit || (state != LOAD) || (idx == 3'd0)) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            to_flag <= 1'b0;
        end else if (accept && (idx == 3'd0)) begin
            to_flag <= 1'b0;
        end else if (timeout_hit) begin
            to_flag <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign to_flag     = 1'b0;
`endif

    assign bus.op_a         = a_q;
    assign bus.op_b         = b_q;
    assign bus.op_sel       = sel_q;
    assign bus.byte_idx     = idx;
    assign bus.timeout_flag = to_flag;

endmodule

// File: tb/tb_fp32_operand_loader.sv
// Self-checking bench for fp32_operand_loader; expected pairs come from the byte streams sent.
// Inputs are driven and outputs sampled on the falling edge.
module tb_fp32_operand_loader;

`ifdef LOADER_TIMEOUT_EN
    localparam int TO_CYC = 10;
`else
    localparam int TO_CYC = 255;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    fp32_operand_loader_if bus ();

    fp32_operand_loader #(.TIMEOUT_CYCLES(TO_CYC), .TO_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pack8(input logic [7:0] b[8]);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++) r = r | (64'(b[i]) << (8 * (7 - i)));
        return r;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input logic s);
        bus.byte_in    = b;
        bus.op_sel_in  = s;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        bus.byte_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_tests++; if (bus.byte_ready !== 1'b1) begin n_fail++; $display("FAIL reset_byte_ready got %0b want 1", bus.byte_ready); end
        n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL reset_op_valid got %0b want 0", bus.op_valid); end
        n_tests++; if ({bus.op_a, bus.op_b} !== 64'd0) begin n_fail++; $display("FAIL reset_ops got %h want 0", {bus.op_a, bus.op_b}); end
        n_tests++; if ({bus.op_sel, bus.byte_idx, bus.timeout_flag} !== 5'd0) begin n_fail++; $display("FAIL reset_misc got %b want 0", {bus.op_sel, bus.byte_idx, bus.timeout_flag}); end
    endtask

    task automatic test_basic();
        logic [7:0] b[8] = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
        bus.op_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (bus.op_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid byte %0d got %0b want 0", i, bus.op_valid); end
            drive_byte(b[i], 1'b0);
        end
        n_tests++; if (bus.op_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", bus.op_valid); end
        n_tests++; if (bus.op_a !== 32'h3F800000) begin n_fail++; $display("FAIL basic_op_a got %h want 3f800000", bus.op_a); end
        n_tests++; if (bus.op_b !== 32'h40000000) begin n_fail++; $display("FAIL basic_op_b got %h want 40000000", bus.op_b); end
        n_tests++; if ({bus.op_sel, bus.byte_ready, bus.byte_idx} !== 5'b00000) begin n_fail++; $display("FAIL basic_issue_misc got %b want 00000", {bus.op_sel, bus.byte_ready, bus.byte_idx}); end
        @(negedge clk);
        n_tests++; if ({bus.op_valid, bus.byte_ready} !== 2'b01) begin n_fail++; $display("FAIL basic_after_xfer got %b want 01", {bus.op_valid, bus.byte_ready}); end
        n_tests++; if (bus.op_a !== 32'h3F800000) begin n_fail++; $display("FAIL basic_hold_a got %h want 3f800000", bus.op_a); end
    endtask

    task automatic test_backpressure();
        logic [7:0]  b[8];
        logic [63:0] exp;
        logic        s = 1'($urandom);
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
        exp = pack8(b);
        bus.op_ready = 1'b0;
        for (int i = 0; i < 8; i++) drive_byte(b[i], (i == 0) ? s : ~s);
        bus.byte_in    = 8'hC3;
        bus.op_sel_in  = 1'b0;
        bus.byte_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            n_tests++; if ({bus.byte_ready, bus.op_valid} !== 2'b01) begin n_fail++; $display("FAIL bp_hs cyc %0d got %b want 01", c, {bus.byte_ready, bus.op_valid}); end
            n_tests++; if ({bus.op_a, bus.op_b, bus.op_sel} !== {exp, s}) begin n_fail++; $display("FAIL bp_stable cyc %0d got %h want %h", c, {bus.op_a, bus.op_b, bus.op_sel}, {exp, s}); end
            @(negedge clk);
        end
        bus.op_ready = 1'b1;
        @(negedge clk);
        bus.op_ready = 1'b0;
        n_tests++; if ({bus.op_valid, bus.byte_ready, bus.byte_idx} !== 5'b01000) begin n_fail++; $display("FAIL bp_release got %b want 01000", {bus.op_valid, bus.byte_ready, bus.byte_idx}); end
        @(negedge clk);
        bus.byte_valid = 1'b0;
        n_tests++; if (bus.byte_idx !== 3'd1) begin n_fail++; $display("FAIL bp_c3_idx got %0d want 1", bus.byte_idx); end
        n_tests++; if (bus.op_a !== {8'hC3, exp[55:32]}) begin n_fail++; $display("FAIL bp_c3_lane got %h want %h", bus.op_a, {8'hC3, exp[55:32]}); end
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    task automatic test_clear();
        logic [7:0] p[4];
        logic [7:0] b[8];
        logic [31:0] old_b = bus.op_b;
        logic        old_s = bus.op_sel;
        for (int i = 0; i < 4; i++) p[i] = 8'($urandom);
        for (int i = 0; i < 4; i++) drive_byte(p[i], ~old_s);
        bus.clear      = 1'b1;
        bus.byte_in    = 8'hEE;
        bus.byte_valid = 1'b1;
        @(negedge clk);
        bus.clear      = 1'b0;
        bus.byte_valid = 1'b0;
        n_tests++; if ({bus.byte_idx, bus.op_valid} !== 4'd0) begin n_fail++; $display("FAIL clear_idx got %b want 0000", {bus.byte_idx, bus.op_valid}); end
        n_tests++; if ({bus.op_a, bus.op_b, bus.op_sel} !== {p[0], p[1], p[2], p[3], old_b, ~old_s}) begin n_fail++; $display("FAIL clear_keep got %h want %h", {bus.op_a, bus.op_b, bus.op_sel}, {p[0], p[1], p[2], p[3], old_b, ~old_s}); end
        for (int i = 0; i < 8; i++) b[i] = 8'(8'h11 + i);
        bus.op_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive_byte(b[i], 1'b1);
        n_tests++; if ({bus.op_valid, bus.op_a, bus.op_b, bus.op_sel} !== {1'b1, 64'h1112131415161718, 1'b1}) begin n_fail++; $display("FAIL clear_reload got %h want %h", {bus.op_valid, bus.op_a, bus.op_b, bus.op_sel}, {1'b1, 64'h1112131415161718, 1'b1}); end
        @(negedge clk);
        // clear together with a completing handshake: transfer done, back to LOAD
        for (int i = 0; i < 8; i++) drive_byte(8'($urandom), 1'b0);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        n_tests++; if ({bus.op_valid, bus.byte_ready, bus.byte_idx} !== 5'b01000) begin n_fail++; $display("FAIL clear_issue got %b want 01000", {bus.op_valid, bus.byte_ready, bus.byte_idx}); end
    endtask

    task automatic test_rst_midload();
        for (int i = 0; i < 6; i++) drive_byte(8'($urandom_range(1, 255)), 1'b1);
        n_tests++; if (bus.byte_idx !== 3'd6) begin n_fail++; $display("FAIL rst_pre_idx got %0d want 6", bus.byte_idx); end
        do_reset();
        n_tests++; if ({bus.op_a, bus.op_b, bus.op_sel, bus.op_valid, bus.byte_idx, bus.timeout_flag, bus.byte_ready} !== {64'd0, 7'b0000001}) begin n_fail++; $display("FAIL rst_mid got %h want 1", {bus.op_a, bus.op_b, bus.op_sel, bus.op_valid, bus.byte_idx, bus.timeout_flag, bus.byte_ready}); end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 3; i++) drive_byte(8'($urandom), 1'b0);
        repeat (9) @(negedge clk);
        n_tests++; if ({bus.byte_idx, bus.timeout_flag} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL to_before got %b want 0110", {bus.byte_idx, bus.timeout_flag}); end
        @(negedge clk);
`ifdef LOADER_TIMEOUT_EN
        n_tests++; if ({bus.byte_idx, bus.timeout_flag} !== {3'd0, 1'b1}) begin n_fail++; $display("FAIL to_fire got %b want 0001", {bus.byte_idx, bus.timeout_flag}); end
        drive_byte(8'h5A, 1'b0);
        n_tests++; if ({bus.byte_idx, bus.timeout_flag, bus.op_a[31:24]} !== {3'd1, 1'b0, 8'h5A}) begin n_fail++; $display("FAIL to_clear got %h want 25a", {bus.byte_idx, bus.timeout_flag, bus.op_a[31:24]}); end
`else
        n_tests++; if ({bus.byte_idx, bus.timeout_flag} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL to_disabled got %b want 0110", {bus.byte_idx, bus.timeout_flag}); end
`endif
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [7:0]  stream[32];
        logic        sel[32];
        logic [7:0]  grp[8];
        int          ptr = 0;
        int          pairs = 0;
        int          last = 0;
        for (int i = 0; i < 32; i++) begin
            stream[i] = 8'($urandom);
            sel[i]    = 1'($urandom);
        end
        bus.op_ready = 1'b1;
        for (int cyc = 0; cyc < 80 && pairs < 3; cyc++) begin
            bus.byte_in    = stream[ptr];
            bus.op_sel_in  = sel[ptr];
            bus.byte_valid = 1'b1;
            if (bus.op_valid) begin
                for (int i = 0; i < 8; i++) grp[i] = stream[8 * pairs + i];
                n_tests++; if ({bus.op_a, bus.op_b, bus.op_sel} !== {pack8(grp), sel[8 * pairs]}) begin n_fail++; $display("FAIL b2b_pair%0d got %h want %h", pairs, {bus.op_a, bus.op_b, bus.op_sel}, {pack8(grp), sel[8 * pairs]}); end
                if (pairs > 0) begin
                    n_tests++; if (cyc - last != 9) begin n_fail++; $display("FAIL b2b_period%0d got %0d want 9", pairs, cyc - last); end
                end
                last = cyc;
                pairs++;
            end
            if (bus.byte_ready) ptr++;
            @(negedge clk);
        end
        bus.byte_valid = 1'b0;
        n_tests++; if (pairs != 3) begin n_fail++; $display("FAIL b2b_pairs got %0d want 3", pairs); end
        n_tests++; if (ptr != 24) begin n_fail++; $display("FAIL b2b_consumed got %0d want 24", ptr); end
    endtask

    initial begin
        bus.byte_in    = 8'd0;
        bus.byte_valid = 1'b0;
        bus.op_sel_in  = 1'b0;
        bus.clear      = 1'b0;
        bus.op_ready   = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_backpressure();
        test_clear();
        test_rst_midload();
        test_timeout();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
